// File: rtl/id_ex_hazard_reg_if.sv
// rtl/id_ex_hazard_reg_if.sv - decode/execute boundary signals for the ID/EX hazard register
interface id_ex_hazard_reg_if #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              DE_valid;
    logic [31:0]       DE_PC;
    logic [31:0]       DE_IR;
    logic [31:0]       DE_rs1_val;
    logic [31:0]       DE_rs2_val;
    logic [CTRL_W-1:0] DE_ctrl;
    logic              DE_memRead;
    logic              EX_branch_taken;

    logic              EX_valid;
    logic [31:0]       EX_PC;
    logic [31:0]       EX_IR;
    logic [31:0]       EX_rs1_val;
    logic [31:0]       EX_rs2_val;
    logic [CTRL_W-1:0] EX_ctrl;
    logic              EX_memRead;
    logic [4:0]        EX_rs1_addr;
    logic [4:0]        EX_rs2_addr;
    logic [4:0]        EX_rd_addr;
    logic              stall_fetch;
    logic              stall_decode;
    logic              flush_decode;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output DE_valid, DE_PC, DE_IR, DE_rs1_val, DE_rs2_val, DE_ctrl, DE_memRead,
               EX_branch_taken,
        input  EX_valid, EX_PC, EX_IR, EX_rs1_val, EX_rs2_val, EX_ctrl, EX_memRead,
               EX_rs1_addr, EX_rs2_addr, EX_rd_addr,
               stall_fetch, stall_decode, flush_decode, stall_count, flush_count
    );

    modport slave (
        input  DE_valid, DE_PC, DE_IR, DE_rs1_val, DE_rs2_val, DE_ctrl, DE_memRead,
               EX_branch_taken,
        output EX_valid, EX_PC, EX_IR, EX_rs1_val, EX_rs2_val, EX_ctrl, EX_memRead,
               EX_rs1_addr, EX_rs2_addr, EX_rd_addr,
               stall_fetch, stall_decode, flush_decode, stall_count, flush_count
    );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use stall and branch flush
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module id_ex_hazard_reg #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    id_ex_hazard_reg_if.slave bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       ir;
        logic [31:0]       rs1_val;
        logic [31:0]       rs2_val;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
    } ex_t;

    state_t state_q, state_d;
    ex_t    ex_q, ex_d;

    logic [6:0] opcode;
    logic       rs1_used, rs2_used, rd_used;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       hazard, flush, stall;

    always_comb begin
        opcode   = bus.DE_IR[6:0];
        rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        rs2_used = (opcode == OP_R || opcode == OP_S || opcode == OP_B);
        rd_used  = !(opcode == OP_S || opcode == OP_B);
        de_rs1   = rs1_used ? bus.DE_IR[19:15] : 5'd0;
        de_rs2   = rs2_used ? bus.DE_IR[24:20] : 5'd0;
        de_rd    = rd_used  ? bus.DE_IR[11:7]  : 5'd0;

        // Gated addresses are zero when unused, and ex_q.rd_addr is nonzero here, so no false match.
        hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) && bus.DE_valid &&
                 ((de_rs1 == ex_q.rd_addr) || (de_rs2 == ex_q.rd_addr));
        flush  = bus.EX_branch_taken;
        stall  = hazard && !flush;

        ex_d = '0;
        if (!flush && !stall) begin
            ex_d.valid    = bus.DE_valid;
            ex_d.pc       = bus.DE_PC;
            ex_d.ir       = bus.DE_IR;
            ex_d.rs1_val  = bus.DE_rs1_val;
            ex_d.rs2_val  = bus.DE_rs2_val;
            ex_d.ctrl     = bus.DE_ctrl;
            ex_d.mem_read = bus.DE_memRead;
            ex_d.rs1_addr = de_rs1;
            ex_d.rs2_addr = de_rs2;
            ex_d.rd_addr  = de_rd;
        end

        case (state_q)
            LOAD_STALL, FLUSH: state_d = flush ? FLUSH : RUN;
            default:           state_d = flush ? FLUSH : (stall ? LOAD_STALL : RUN);
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
        end
    end

    assign bus.stall_fetch  = stall && !RST;
    assign bus.stall_decode = stall && !RST;
    assign bus.flush_decode = flush && !RST;

    assign bus.EX_valid    = ex_q.valid;
    assign bus.EX_PC       = ex_q.pc;
    assign bus.EX_IR       = ex_q.ir;
    assign bus.EX_rs1_val  = ex_q.rs1_val;
    assign bus.EX_rs2_val  = ex_q.rs2_val;
    assign bus.EX_ctrl     = ex_q.ctrl;
    assign bus.EX_memRead  = ex_q.mem_read;
    assign bus.EX_rs1_addr = ex_q.rs1_addr;
    assign bus.EX_rs2_addr = ex_q.rs2_addr;
    assign bus.EX_rd_addr  = ex_q.rd_addr;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - scoreboard bench for id_ex_hazard_reg
module tb_id_ex_hazard_reg;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_565 = 32'h00228333;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_000 = 32'h00000333;
    localparam logic [31:0] LUI_X5  = 32'h000282B7;
    localparam logic [31:0] LW_X7   = 32'h0002A383;
    localparam logic [31:0] ADD_672 = 32'h00238333;
    localparam logic [31:0] SW_X5   = 32'h0050A023;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    id_ex_hazard_reg_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bif ();
    id_ex_hazard_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bif.slave));

    typedef struct {
        logic              stall;
        logic              flush;
        logic              valid;
        logic [31:0]       pc, ir, v1, v2;
        logic [CTRL_W-1:0] ctrl;
        logic              mr;
        logic [4:0]        a1, a2, ad;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] pc_ctr = 32'h100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [31:0] ir, input logic mr, input logic br,
                         input logic e_stall, input logic e_flush, input logic e_bub,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        exp_t e;
        @(posedge CLK);
        #1;
        bif.DE_valid        = v;
        bif.DE_PC           = pc_ctr;
        bif.DE_IR           = ir;
        bif.DE_rs1_val      = $urandom;
        bif.DE_rs2_val      = $urandom;
        bif.DE_ctrl         = CTRL_W'($urandom);
        bif.DE_memRead      = mr;
        bif.EX_branch_taken = br;
        pc_ctr += 32'd4;
        e.stall = e_stall;
        e.flush = e_flush;
        if (e_bub) begin
            e.valid = 0; e.pc = 0; e.ir = 0; e.v1 = 0; e.v2 = 0; e.ctrl = 0; e.mr = 0;
            e.a1 = 0; e.a2 = 0; e.ad = 0;
        end else begin
            e.valid = v; e.pc = bif.DE_PC; e.ir = ir; e.v1 = bif.DE_rs1_val;
            e.v2 = bif.DE_rs2_val; e.ctrl = bif.DE_ctrl; e.mr = mr;
            e.a1 = a1; e.a2 = a2; e.ad = ad;
        end
        sb.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(posedge CLK);
            t++;
        end
        #3;
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (sb.size() > 0);
            @(negedge CLK);
            e = sb[0];
            chk("stall_fetch",  64'(bif.stall_fetch),  64'(e.stall));
            chk("stall_decode", 64'(bif.stall_decode), 64'(e.stall));
            chk("flush_decode", 64'(bif.flush_decode), 64'(e.flush));
            @(posedge CLK);
            #2;
            e = sb.pop_front();
            chk("EX_valid",    64'(bif.EX_valid),    64'(e.valid));
            chk("EX_PC",       64'(bif.EX_PC),       64'(e.pc));
            chk("EX_IR",       64'(bif.EX_IR),       64'(e.ir));
            chk("EX_rs1_val",  64'(bif.EX_rs1_val),  64'(e.v1));
            chk("EX_rs2_val",  64'(bif.EX_rs2_val),  64'(e.v2));
            chk("EX_ctrl",     64'(bif.EX_ctrl),     64'(e.ctrl));
            chk("EX_memRead",  64'(bif.EX_memRead),  64'(e.mr));
            chk("EX_rs1_addr", 64'(bif.EX_rs1_addr), 64'(e.a1));
            chk("EX_rs2_addr", 64'(bif.EX_rs2_addr), 64'(e.a2));
            chk("EX_rd_addr",  64'(bif.EX_rd_addr),  64'(e.ad));
        end
    end

    initial begin : stim
        bif.DE_valid = 0; bif.DE_PC = 0; bif.DE_IR = 0; bif.DE_rs1_val = 0;
        bif.DE_rs2_val = 0; bif.DE_ctrl = 0; bif.DE_memRead = 0; bif.EX_branch_taken = 1;
        #12;
        chk("rst_EX_valid",     64'(bif.EX_valid),     64'd0);
        chk("rst_EX_IR",        64'(bif.EX_IR),        64'd0);
        chk("rst_EX_PC",        64'(bif.EX_PC),        64'd0);
        chk("rst_EX_rd_addr",   64'(bif.EX_rd_addr),   64'd0);
        chk("rst_flush_decode", 64'(bif.flush_decode), 64'd0);
        chk("rst_stall_fetch",  64'(bif.stall_fetch),  64'd0);
        chk("rst_stall_count",  64'(bif.stall_count),  64'd0);
        chk("rst_flush_count",  64'(bif.flush_count),  64'd0);
        bif.EX_branch_taken = 0;
        @(negedge CLK);
        RST = 0;

        // valid, ir, memRead, branch, stall, flush, bubble, rs1, rs2, rd
        issue(1, LW_X5,   1, 0, 0, 0, 0, 1, 0, 5);
        issue(1, ADD_565, 0, 0, 1, 0, 1, 0, 0, 0);
        issue(1, ADD_565, 0, 0, 0, 0, 0, 5, 2, 6);
        issue(1, LW_X0,   1, 0, 0, 0, 0, 1, 0, 0);
        issue(1, ADD_000, 0, 0, 0, 0, 0, 0, 0, 6);
        issue(1, LW_X5,   1, 0, 0, 0, 0, 1, 0, 5);
        issue(1, LUI_X5,  0, 0, 0, 0, 0, 0, 0, 5);
        issue(1, LW_X5,   1, 0, 0, 0, 0, 1, 0, 5);
        issue(1, ADD_565, 0, 1, 0, 1, 1, 0, 0, 0);
        issue(0, 32'd0,   0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, LW_X5,   1, 0, 0, 0, 0, 1, 0, 5);
        issue(1, LW_X7,   1, 0, 1, 0, 1, 0, 0, 0);
        issue(1, LW_X7,   1, 0, 0, 0, 0, 5, 0, 7);
        issue(1, ADD_672, 0, 0, 1, 0, 1, 0, 0, 0);
        issue(1, ADD_672, 0, 0, 0, 0, 0, 7, 2, 6);
        issue(1, LW_X5,   1, 0, 0, 0, 0, 1, 0, 5);
        issue(1, SW_X5,   0, 0, 1, 0, 1, 0, 0, 0);
        issue(1, SW_X5,   0, 0, 0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 20; i++) begin
            issue(1, LW_X5,   1, 0, 0, 0, 0, 1, 0, 5);
            issue(1, ADD_565, 0, 0, 1, 0, 1, 0, 0, 0);
            issue(1, ADD_565, 0, 0, 0, 0, 0, 5, 2, 6);
        end
        issue(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

`ifdef HAZARD_PERF_CNT_EN
        chk("stall_count_sat", 64'(bif.stall_count), 64'd15);
        chk("flush_count",     64'(bif.flush_count), 64'd1);
`else
        chk("stall_count_off", 64'(bif.stall_count), 64'd0);
        chk("flush_count_off", 64'(bif.flush_count), 64'd0);
`endif

        issue(1, LW_X5, 1, 0, 0, 0, 0, 1, 0, 5);
        drain();
        bif.DE_valid = 1; bif.DE_IR = ADD_565; bif.DE_memRead = 0;
        #1;
        chk("pre_rst_stall_fetch", 64'(bif.stall_fetch), 64'd1);
        RST = 1;
        #1;
        chk("mid_rst_stall_fetch",  64'(bif.stall_fetch),  64'd0);
        chk("mid_rst_stall_decode", 64'(bif.stall_decode), 64'd0);
        chk("mid_rst_EX_valid",     64'(bif.EX_valid),     64'd0);
        chk("mid_rst_EX_IR",        64'(bif.EX_IR),        64'd0);
        chk("mid_rst_EX_memRead",   64'(bif.EX_memRead),   64'd0);
        chk("mid_rst_EX_rd_addr",   64'(bif.EX_rd_addr),   64'd0);
        chk("mid_rst_stall_count",  64'(bif.stall_count),  64'd0);
        @(posedge CLK);
        #2;
        chk("held_rst_EX_valid", 64'(bif.EX_valid), 64'd0);
        chk("held_rst_EX_PC",    64'(bif.EX_PC),    64'd0);
        bif.DE_valid = 0;
        @(negedge CLK);
        RST = 0;
        @(posedge CLK);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
